// File: rtl/axi_mm_pipe_bridge.sv
// AXI-MM pipeline bridge: skid-buffer pipes on all five channels, freeze gating on
// outbound requests, outstanding-transaction throttling and idle reporting.

module axi_mm_pipe_stage #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             busy
);
    logic             main_vld;
    logic             skid_vld;
    logic [WIDTH-1:0] main_data;
    logic [WIDTH-1:0] skid_data;
    logic             main_load;
    logic             skid_load;

    // Main entry refills whenever it is empty or draining; the skid entry only
    // catches the beat accepted while the main entry is stalled.
    assign main_load = !main_vld || out_ready;
    assign skid_load = !main_load && in_valid && !skid_vld;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_vld <= 1'b0;
            skid_vld <= 1'b0;
        end else if (main_load) begin
            main_vld <= skid_vld || in_valid;
            skid_vld <= 1'b0;
        end else if (skid_load) begin
            skid_vld <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (main_load) main_data <= skid_vld ? skid_data : in_data;
        if (skid_load) skid_data <= in_data;
    end

    assign in_ready  = !skid_vld;
    assign out_valid = main_vld;
    assign out_data  = main_data;
    assign busy      = main_vld || skid_vld;
endmodule

module axi_mm_pipe_chain #(
    parameter int WIDTH      = 8,
    parameter int NUM_STAGES = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             busy
);
    logic             vld [NUM_STAGES+1];
    logic             rdy [NUM_STAGES+1];
    logic [WIDTH-1:0] dat [NUM_STAGES+1];
    logic [NUM_STAGES:0] stage_busy;

    assign vld[0]             = in_valid;
    assign dat[0]             = in_data;
    assign in_ready           = rdy[0];
    assign rdy[NUM_STAGES]    = out_ready;
    assign out_valid          = vld[NUM_STAGES];
    assign out_data           = dat[NUM_STAGES];
    assign stage_busy[0]      = 1'b0;

    for (genvar i = 0; i < NUM_STAGES; i++) begin : g_stage
        axi_mm_pipe_stage #(.WIDTH(WIDTH)) u_stage (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (vld[i]),
            .in_ready  (rdy[i]),
            .in_data   (dat[i]),
            .out_valid (vld[i+1]),
            .out_ready (rdy[i+1]),
            .out_data  (dat[i+1]),
            .busy      (stage_busy[i+1])
        );
    end

    assign busy = |stage_busy;
endmodule

module axi_mm_pipe_bridge #(
    parameter int AW_W            = 64,
    parameter int W_W             = 580,
    parameter int B_W             = 16,
    parameter int AR_W            = 64,
    parameter int R_W             = 560,
    parameter int NUM_STAGES      = 1,
    parameter int MAX_OUTSTANDING = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [2:0]      s_fwd_valid,
    output logic [2:0]      s_fwd_ready,
    input  logic [AW_W-1:0] s_aw_data,
    input  logic [W_W-1:0]  s_w_data,
    input  logic [AR_W-1:0] s_ar_data,
    output logic [2:0]      m_fwd_valid,
    input  logic [2:0]      m_fwd_ready,
    output logic [AW_W-1:0] m_aw_data,
    output logic [W_W-1:0]  m_w_data,
    output logic [AR_W-1:0] m_ar_data,
    input  logic [1:0]      m_rev_valid,
    output logic [1:0]      m_rev_ready,
    input  logic [B_W-1:0]  m_b_data,
    input  logic [R_W-1:0]  m_r_data,
    input  logic            m_r_last,
    output logic [1:0]      s_rev_valid,
    input  logic [1:0]      s_rev_ready,
    output logic [B_W-1:0]  s_b_data,
    output logic [R_W-1:0]  s_r_data,
    output logic            s_r_last,
    input  logic            freeze,
    output logic [7:0]      wr_outstanding,
    output logic [7:0]      rd_outstanding,
    output logic            idle,
    output logic            err_unexpected
);
    localparam logic [7:0] MAX_CNT = 8'(MAX_OUTSTANDING);

    logic [2:0] fwd_valid;
    logic [2:0] fwd_ready;
    logic [2:0] gate;
    logic [4:0] busy;
    logic [R_W:0] r_out;
    logic aw_fire, ar_fire, b_fire, r_done, underflow;

    function automatic logic [7:0] next_count(input logic [7:0] cnt, input logic inc,
                                              input logic dec);
        if (inc && !dec) return cnt + 8'd1;
        if (dec && !inc && cnt != 8'd0) return cnt - 8'd1;
        return cnt;
    endfunction

    axi_mm_pipe_chain #(.WIDTH(AW_W), .NUM_STAGES(NUM_STAGES)) u_aw (
        .clk(clk), .rst_n(rst_n), .in_valid(s_fwd_valid[0]), .in_ready(s_fwd_ready[0]),
        .in_data(s_aw_data), .out_valid(fwd_valid[0]), .out_ready(fwd_ready[0]),
        .out_data(m_aw_data), .busy(busy[0]));

    axi_mm_pipe_chain #(.WIDTH(W_W), .NUM_STAGES(NUM_STAGES)) u_w (
        .clk(clk), .rst_n(rst_n), .in_valid(s_fwd_valid[1]), .in_ready(s_fwd_ready[1]),
        .in_data(s_w_data), .out_valid(fwd_valid[1]), .out_ready(fwd_ready[1]),
        .out_data(m_w_data), .busy(busy[1]));

    axi_mm_pipe_chain #(.WIDTH(AR_W), .NUM_STAGES(NUM_STAGES)) u_ar (
        .clk(clk), .rst_n(rst_n), .in_valid(s_fwd_valid[2]), .in_ready(s_fwd_ready[2]),
        .in_data(s_ar_data), .out_valid(fwd_valid[2]), .out_ready(fwd_ready[2]),
        .out_data(m_ar_data), .busy(busy[2]));

    axi_mm_pipe_chain #(.WIDTH(B_W), .NUM_STAGES(NUM_STAGES)) u_b (
        .clk(clk), .rst_n(rst_n), .in_valid(m_rev_valid[0]), .in_ready(m_rev_ready[0]),
        .in_data(m_b_data), .out_valid(s_rev_valid[0]), .out_ready(s_rev_ready[0]),
        .out_data(s_b_data), .busy(busy[3]));

    axi_mm_pipe_chain #(.WIDTH(R_W + 1), .NUM_STAGES(NUM_STAGES)) u_r (
        .clk(clk), .rst_n(rst_n), .in_valid(m_rev_valid[1]), .in_ready(m_rev_ready[1]),
        .in_data({m_r_last, m_r_data}), .out_valid(s_rev_valid[1]), .out_ready(s_rev_ready[1]),
        .out_data(r_out), .busy(busy[4]));

    assign {s_r_last, s_r_data} = r_out;

    // Ready is masked together with valid so a gated beat stays in the last stage.
    assign gate[0]     = !freeze && (wr_outstanding != MAX_CNT);
    assign gate[1]     = !freeze;
    assign gate[2]     = !freeze && (rd_outstanding != MAX_CNT);
    assign m_fwd_valid = fwd_valid & gate;
    assign fwd_ready   = m_fwd_ready & gate;

    assign aw_fire   = m_fwd_valid[0] && m_fwd_ready[0];
    assign ar_fire   = m_fwd_valid[2] && m_fwd_ready[2];
    assign b_fire    = s_rev_valid[0] && s_rev_ready[0];
    assign r_done    = s_rev_valid[1] && s_rev_ready[1] && s_r_last;
    assign underflow = (b_fire && !aw_fire && wr_outstanding == 8'd0) ||
                       (r_done && !ar_fire && rd_outstanding == 8'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_outstanding <= 8'd0;
            rd_outstanding <= 8'd0;
            err_unexpected <= 1'b0;
        end else begin
            wr_outstanding <= next_count(wr_outstanding, aw_fire, b_fire);
            rd_outstanding <= next_count(rd_outstanding, ar_fire, r_done);
            if (underflow) err_unexpected <= 1'b1;
        end
    end

    assign idle = !(|busy) && wr_outstanding == 8'd0 && rd_outstanding == 8'd0;
endmodule

// File: tb/tb_axi_mm_pipe_bridge.sv
// Directed bench for axi_mm_pipe_bridge: two instances share all inputs, one with a
// large outstanding limit for streaming and one with a limit of 4 for throttling.

module tb_axi_mm_pipe_bridge;
    localparam int AW_W = 16, W_W = 16, B_W = 8, AR_W = 16, R_W = 8;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [2:0]      s_fwd_valid = '0;
    logic [AW_W-1:0] s_aw_data = '0;
    logic [W_W-1:0]  s_w_data = '0;
    logic [AR_W-1:0] s_ar_data = '0;
    logic [2:0]      m_fwd_ready = '0;
    logic [1:0]      m_rev_valid = '0;
    logic [B_W-1:0]  m_b_data = '0;
    logic [R_W-1:0]  m_r_data = '0;
    logic            m_r_last = 1'b0;
    logic [1:0]      s_rev_ready = '0;
    logic            freeze = 1'b0;

    logic [2:0] big_s_fwd_ready, big_m_fwd_valid, lim_s_fwd_ready, lim_m_fwd_valid;
    logic [AW_W-1:0] big_m_aw_data, lim_m_aw_data;
    logic [W_W-1:0]  big_m_w_data, lim_m_w_data;
    logic [AR_W-1:0] big_m_ar_data, lim_m_ar_data;
    logic [1:0] big_m_rev_ready, big_s_rev_valid, lim_m_rev_ready, lim_s_rev_valid;
    logic [B_W-1:0] big_s_b_data, lim_s_b_data;
    logic [R_W-1:0] big_s_r_data, lim_s_r_data;
    logic big_s_r_last, lim_s_r_last, big_idle, lim_idle, big_err, lim_err;
    logic [7:0] big_wr, big_rd, lim_wr, lim_rd;

    int errors = 0;
    int checks = 0;
    int tx, rx;
    logic held, fire_s;
    logic [W_W-1:0] held_data;

    always #5 clk = ~clk;

    axi_mm_pipe_bridge #(.AW_W(AW_W), .W_W(W_W), .B_W(B_W), .AR_W(AR_W), .R_W(R_W),
                         .NUM_STAGES(2), .MAX_OUTSTANDING(64)) u_big (
        .clk(clk), .rst_n(rst_n), .s_fwd_valid(s_fwd_valid), .s_fwd_ready(big_s_fwd_ready),
        .s_aw_data(s_aw_data), .s_w_data(s_w_data), .s_ar_data(s_ar_data),
        .m_fwd_valid(big_m_fwd_valid), .m_fwd_ready(m_fwd_ready), .m_aw_data(big_m_aw_data),
        .m_w_data(big_m_w_data), .m_ar_data(big_m_ar_data), .m_rev_valid(m_rev_valid),
        .m_rev_ready(big_m_rev_ready), .m_b_data(m_b_data), .m_r_data(m_r_data),
        .m_r_last(m_r_last), .s_rev_valid(big_s_rev_valid), .s_rev_ready(s_rev_ready),
        .s_b_data(big_s_b_data), .s_r_data(big_s_r_data), .s_r_last(big_s_r_last),
        .freeze(freeze), .wr_outstanding(big_wr), .rd_outstanding(big_rd), .idle(big_idle),
        .err_unexpected(big_err));

    axi_mm_pipe_bridge #(.AW_W(AW_W), .W_W(W_W), .B_W(B_W), .AR_W(AR_W), .R_W(R_W),
                         .NUM_STAGES(2), .MAX_OUTSTANDING(4)) u_lim (
        .clk(clk), .rst_n(rst_n), .s_fwd_valid(s_fwd_valid), .s_fwd_ready(lim_s_fwd_ready),
        .s_aw_data(s_aw_data), .s_w_data(s_w_data), .s_ar_data(s_ar_data),
        .m_fwd_valid(lim_m_fwd_valid), .m_fwd_ready(m_fwd_ready), .m_aw_data(lim_m_aw_data),
        .m_w_data(lim_m_w_data), .m_ar_data(lim_m_ar_data), .m_rev_valid(m_rev_valid),
        .m_rev_ready(lim_m_rev_ready), .m_b_data(m_b_data), .m_r_data(m_r_data),
        .m_r_last(m_r_last), .s_rev_valid(lim_s_rev_valid), .s_rev_ready(s_rev_ready),
        .s_b_data(lim_s_b_data), .s_r_data(lim_s_r_data), .s_r_last(lim_s_r_last),
        .freeze(freeze), .wr_outstanding(lim_wr), .rd_outstanding(lim_rd), .idle(lim_idle),
        .err_unexpected(lim_err));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        s_fwd_valid = '0;
        m_rev_valid = '0;
        m_r_last    = 1'b0;
        freeze      = 1'b0;
        rst_n       = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
    endtask

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_m_fwd_valid", 32'(big_m_fwd_valid), 32'd0);
        check("rst_s_rev_valid", 32'(big_s_rev_valid), 32'd0);
        check("rst_idle", 32'(big_idle), 32'd1);
        check("rst_wr", 32'(lim_wr), 32'd0);
        check("rst_rd", 32'(lim_rd), 32'd0);
        check("rst_err", 32'(lim_err), 32'd0);
        rst_n = 1'b1;
        step();
        check("rst_s_fwd_ready", 32'(big_s_fwd_ready), 32'h7);
        check("rst_m_rev_ready", 32'(big_m_rev_ready), 32'h3);

        // Eight back-to-back AW beats through two stages
        m_fwd_ready = 3'b111;
        s_rev_ready = 2'b11;
        for (int c = 0; c < 10; c++) begin
            s_fwd_valid[0] = (c < 8);
            s_aw_data      = AW_W'(16'h0100 + c);
            if (c < 8) check("aw_s_ready", 32'(big_s_fwd_ready[0]), 32'd1);
            step();
            check("aw_m_valid", 32'(big_m_fwd_valid[0]), 32'((c >= 1) && (c <= 8)));
            if (c >= 1 && c <= 8) check("aw_m_data", 32'(big_m_aw_data), 32'(16'h0100 + c - 1));
        end
        s_fwd_valid = '0;
        check("aw_wr_count", 32'(big_wr), 32'd8);

        // W stream under random downstream backpressure
        do_reset();
        s_rev_ready = 2'b11;
        tx = 0;
        rx = 0;
        held = 1'b0;
        held_data = '0;
        for (int c = 0; c < 400 && rx < 32; c++) begin
            m_fwd_ready    = {1'b0, ($urandom_range(0, 1) == 1), 1'b0};
            s_fwd_valid[1] = (tx < 32);
            s_w_data       = W_W'(16'h0200 + tx);
            #1;
            if (held) begin
                check("w_hold_valid", 32'(big_m_fwd_valid[1]), 32'd1);
                check("w_hold_data", 32'(big_m_w_data), 32'(held_data));
            end
            if (tx - rx >= 3) check("w_no_bubble", 32'(big_m_fwd_valid[1]), 32'd1);
            if (big_m_fwd_valid[1] && m_fwd_ready[1]) begin
                check("w_data_order", 32'(big_m_w_data), 32'(16'h0200 + rx));
                rx++;
            end
            held      = big_m_fwd_valid[1] && !m_fwd_ready[1];
            held_data = big_m_w_data;
            fire_s    = s_fwd_valid[1] && big_s_fwd_ready[1];
            step();
            if (fire_s) tx++;
        end
        s_fwd_valid = '0;
        m_fwd_ready = 3'b111;
        check("w_all_delivered", 32'(rx), 32'd32);
        repeat (3) step();
        check("w_no_extra", 32'(big_m_fwd_valid[1]), 32'd0);

        // AR throttling at a limit of 4
        do_reset();
        m_fwd_ready = 3'b111;
        s_rev_ready = 2'b11;
        tx = 0;
        rx = 0;
        for (int c = 0; c < 12; c++) begin
            s_fwd_valid[2] = (tx < 6);
            s_ar_data      = AR_W'(16'h0300 + tx);
            #1;
            fire_s = s_fwd_valid[2] && lim_s_fwd_ready[2];
            if (lim_m_fwd_valid[2] && m_fwd_ready[2]) begin
                check("ar_order", 32'(lim_m_ar_data), 32'(16'h0300 + rx));
                rx++;
            end
            step();
            if (fire_s) tx++;
        end
        s_fwd_valid = '0;
        check("ar_issued", 32'(rx), 32'd4);
        check("ar_all_accepted", 32'(tx), 32'd6);
        check("ar_rd_count", 32'(lim_rd), 32'd4);
        check("ar_masked", 32'(lim_m_fwd_valid[2]), 32'd0);
        m_rev_valid[1] = 1'b1;
        m_r_last       = 1'b1;
        m_r_data       = 8'hA5;
        #1;
        check("r_m_ready", 32'(lim_m_rev_ready[1]), 32'd1);
        step();
        m_rev_valid[1] = 1'b0;
        m_r_last       = 1'b0;
        step();
        check("r_s_valid", 32'(lim_s_rev_valid[1]), 32'd1);
        check("r_s_data", 32'(lim_s_r_data), 32'hA5);
        check("r_s_last", 32'(lim_s_r_last), 32'd1);
        check("r_rd_before", 32'(lim_rd), 32'd4);
        step();
        check("r_rd_after", 32'(lim_rd), 32'd3);
        check("ar5_valid", 32'(lim_m_fwd_valid[2]), 32'd1);
        check("ar5_data", 32'(lim_m_ar_data), 32'h0304);
        step();
        check("ar5_rd", 32'(lim_rd), 32'd4);
        check("ar6_masked", 32'(lim_m_fwd_valid[2]), 32'd0);

        // Freeze with three reads outstanding, responses still drain
        do_reset();
        m_fwd_ready = 3'b111;
        s_rev_ready = 2'b11;
        for (int c = 0; c < 3; c++) begin
            s_fwd_valid[2] = 1'b1;
            s_ar_data      = AR_W'(16'h0400 + c);
            step();
        end
        s_fwd_valid = '0;
        for (int c = 0; c < 10 && lim_rd != 8'd3; c++) step();
        check("frz_rd3", 32'(lim_rd), 32'd3);
        freeze         = 1'b1;
        m_rev_valid[1] = 1'b1;
        m_r_last       = 1'b1;
        for (int c = 0; c < 3; c++) begin
            m_r_data = R_W'(8'h50 + c);
            #1;
            check("frz_r_ready", 32'(lim_m_rev_ready[1]), 32'd1);
            step();
        end
        m_rev_valid = '0;
        m_r_last    = 1'b0;
        for (int c = 0; c < 10 && !lim_idle; c++) step();
        check("frz_rd0", 32'(lim_rd), 32'd0);
        check("frz_idle", 32'(lim_idle), 32'd1);
        check("frz_err", 32'(lim_err), 32'd0);
        s_fwd_valid[2] = 1'b1;
        s_ar_data      = 16'h0403;
        step();
        s_fwd_valid = '0;
        step();
        step();
        check("frz_masked", 32'(lim_m_fwd_valid[2]), 32'd0);
        check("frz_not_idle", 32'(lim_idle), 32'd0);
        check("frz_rd_hold", 32'(lim_rd), 32'd0);
        freeze = 1'b0;
        #1;
        check("unfrz_valid", 32'(lim_m_fwd_valid[2]), 32'd1);
        check("unfrz_data", 32'(lim_m_ar_data), 32'h0403);
        step();
        check("unfrz_rd", 32'(lim_rd), 32'd1);
        check("unfrz_drained", 32'(lim_m_fwd_valid[2]), 32'd0);

        // Simultaneous AW issue and B return, then B underflow
        do_reset();
        m_fwd_ready = 3'b111;
        s_rev_ready = 2'b11;
        s_fwd_valid[0] = 1'b1;
        s_aw_data = 16'h0601;
        step();
        s_aw_data = 16'h0602;
        step();
        s_fwd_valid = '0;
        repeat (3) step();
        check("wr_two", 32'(lim_wr), 32'd2);
        s_fwd_valid[0] = 1'b1;
        s_aw_data      = 16'h0603;
        m_rev_valid[0] = 1'b1;
        m_b_data       = 8'h11;
        step();
        s_fwd_valid = '0;
        m_rev_valid = '0;
        step();
        check("same_aw_valid", 32'(lim_m_fwd_valid[0]), 32'd1);
        check("same_b_valid", 32'(lim_s_rev_valid[0]), 32'd1);
        check("same_b_data", 32'(lim_s_b_data), 32'h11);
        step();
        check("same_cycle_wr", 32'(lim_wr), 32'd2);
        m_rev_valid[0] = 1'b1;
        step();
        step();
        m_rev_valid = '0;
        repeat (3) step();
        check("b_drain_wr", 32'(lim_wr), 32'd0);
        check("b_drain_err", 32'(lim_err), 32'd0);
        m_rev_valid[0] = 1'b1;
        step();
        m_rev_valid = '0;
        repeat (3) step();
        check("b_under_wr", 32'(lim_wr), 32'd0);
        check("b_under_err", 32'(lim_err), 32'd1);

        // Reset with beats in every stage
        m_fwd_ready = '0;
        s_rev_ready = '0;
        s_fwd_valid = 3'b111;
        m_rev_valid = 2'b11;
        m_r_last    = 1'b1;
        repeat (6) step();
        m_fwd_ready = 3'b100;
        step();
        m_fwd_ready = '0;
        step();
        check("fill_rd", 32'(lim_rd), 32'd1);
        check("fill_not_idle", 32'(lim_idle), 32'd0);
        check("fill_fwd_valid", 32'(lim_m_fwd_valid), 32'h7);
        check("fill_rev_valid", 32'(lim_s_rev_valid), 32'h3);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_fwd_valid", 32'(lim_m_fwd_valid), 32'd0);
        check("arst_rev_valid", 32'(lim_s_rev_valid), 32'd0);
        check("arst_rd", 32'(lim_rd), 32'd0);
        check("arst_idle", 32'(lim_idle), 32'd1);
        check("arst_err", 32'(lim_err), 32'd0);
        s_fwd_valid = '0;
        m_rev_valid = '0;
        m_r_last    = 1'b0;
        m_fwd_ready = 3'b111;
        s_rev_ready = 2'b11;
        step();
        rst_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            step();
            check("post_fwd_valid", 32'(lim_m_fwd_valid), 32'd0);
            check("post_rev_valid", 32'(lim_s_rev_valid), 32'd0);
            check("post_idle", 32'(lim_idle), 32'd1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/axi_mm_pipe_bridge.md
Name: axi_mm_pipe_bridge

Overview:
- Parametrised AXI-MM pipeline bridge placed between an upstream subordinate port and a downstream manager port.
- Inserts NUM_STAGES skid-buffer stages on each of the five channels.
- Adds freeze gating on the outbound AW/W/AR request channels.
- Tracks outstanding writes and reads, throttles issue at MAX_OUTSTANDING, and reports idle status for safe partial-reconfiguration handoff.
- Payloads are opaque packed vectors; only R last is interpreted.

Parameters:
- AW_W, 64: AW payload width (id, addr, len, size, burst, user packed by caller).
- W_W, 580: W payload width.
- B_W, 16: B payload width.
- AR_W, 64: AR payload width.
- R_W, 560: R payload width, excluding the last bit.
- NUM_STAGES, 1: pipeline stages per channel, 0..4; 0 = combinational pass-through.
- MAX_OUTSTANDING, 64: per-direction outstanding limit, 1..255.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- s_fwd_valid  in  3  upstream valid; bit 0 AW, bit 1 W, bit 2 AR.
- s_fwd_ready  out  3  upstream ready, same bit order.
- s_aw_data  in  AW_W  upstream AW payload.
- s_w_data  in  W_W  upstream W payload.
- s_ar_data  in  AR_W  upstream AR payload.
- m_fwd_valid  out  3  downstream valid, same bit order.
- m_fwd_ready  in  3  downstream ready, same bit order.
- m_aw_data  out  AW_W  downstream AW payload.
- m_w_data  out  W_W  downstream W payload.
- m_ar_data  out  AR_W  downstream AR payload.
- m_rev_valid  in  2  downstream response valid; bit 0 B, bit 1 R.
- m_rev_ready  out  2  downstream response ready.
- m_b_data  in  B_W  downstream B payload.
- m_r_data  in  R_W  downstream R payload.
- m_r_last  in  1  downstream R last beat.
- s_rev_valid  out  2  upstream response valid.
- s_rev_ready  in  2  upstream response ready.
- s_b_data  out  B_W  upstream B payload.
- s_r_data  out  R_W  upstream R payload.
- s_r_last  out  1  upstream R last beat.
- freeze  in  1  block new outbound AW/W/AR issue.
- wr_outstanding  out  8  writes issued downstream, B not yet returned upstream.
- rd_outstanding  out  8  reads issued downstream, last R not yet returned upstream.
- idle  out  1  bridge empty and quiescent.
- err_unexpected  out  1  sticky: B or R-last received with count 0.

Behaviour:
- Stage structure:
  - Each stage is a 2-entry skid buffer: registered ready, full throughput, 1 cycle latency per stage.
  - Channel latency = NUM_STAGES cycles.
  - Payload and last held stable while valid && !ready.
  - Beats are never dropped, duplicated or reordered within a channel; channels are independent.
- Reset:
  - All stage valids clear; counters = 0; err_unexpected = 0.
  - m_fwd_valid = 0, s_rev_valid = 0, idle = 1.
  - s_fwd_ready = 1 and m_rev_ready = 1 once reset deasserts (empty buffers).
  - Reset mid-transfer discards all buffered beats without emitting them.
- Output gating (applied after the last stage, combinational):
  - m_fwd_valid[i] = stage_valid[i] & ~freeze, for i = 0..2.
  - The last stage sees ready = m_fwd_ready[i] & ~freeze.
  - Additionally, AW valid is masked while wr_outstanding == MAX_OUTSTANDING, and AR valid is masked while rd_outstanding == MAX_OUTSTANDING.
  - W is not throttled by the count.
  - Freeze asserted while valid && !ready legally withdraws valid. The downstream port is isolated during freeze; the beat is re-presented unchanged when freeze deasserts.
  - B and R are never frozen, so responses drain.
- wr_outstanding:
  - +1 on m-side AW handshake.
  - -1 on s-side B handshake.
  - Both in one cycle: unchanged.
- rd_outstanding:
  - +1 on m-side AR handshake.
  - -1 on s-side R handshake with s_r_last = 1.
  - Both in one cycle: unchanged.
- Counter width is 8 bits.
  - Decrement at 0 holds at 0 and sets err_unexpected, which stays set until reset.
  - Increment at MAX_OUTSTANDING is impossible by construction (issue is masked).
- idle = 1 when all stage valids on all five channels are 0 and both counters are 0 (combinational from registered state).
- NUM_STAGES = 0: all paths are combinational; gating and counters still apply.

Test Plan:
- NUM_STAGES=2: 8 back-to-back AW beats with m_fwd_ready=1 → m_aw_data matches in order; first beat appears 2 cycles after the first s handshake; one beat per cycle thereafter.
- m_fwd_ready[1] toggled randomly while 32 W beats stream → all 32 delivered exactly once, payload stable while stalled, zero bubbles when ready=1.
- MAX_OUTSTANDING=4: issue 6 ARs with no R returned → 4 pass, m_fwd_valid[2]=0 with rd_outstanding=4. One R with last → rd_outstanding=3, fifth AR issues the next cycle.
- freeze=1 mid-burst after 3 ARs are outstanding: m_fwd_valid=0, R continues. After the 3 R-last beats are accepted upstream and pipes drain → idle=1. freeze=0 → held beats resume.
- Same cycle m-side AW and s-side B handshake with wr_outstanding=2 → stays 2. B with wr_outstanding=0 → count stays 0, err_unexpected=1 until reset.
- rst_n asserted with beats in every stage → all valids 0, counters 0, idle=1 immediately; no stale beat emitted after release.
